// File: rtl/uart_pkg.sv
// Shared types and constants for the switch/button UART command sequencer.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CFG_W  = 6;

    // Frame-configuration field layout within o_config
    localparam int unsigned CFG_BAUD_LSB   = 0;
    localparam int unsigned CFG_BAUD_W     = 2;
    localparam int unsigned CFG_PARITY_EN  = 2;
    localparam int unsigned CFG_PARITY_ODD = 3;
    localparam int unsigned CFG_DBITS_LSB  = 4;
    localparam int unsigned CFG_DBITS_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_CFG_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability debounce, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int unsigned       CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             sync_d_q;
    logic             stable_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;
    logic             settled;

    // Synchronised level has held long enough to be accepted
    assign settled = (sync2_q == sync_d_q) && (cnt_q == CNT_MAX);

    // Synchronise, count unchanged cycles (saturating), latch stable level and its rising edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync_d_q <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= i_btn;
            sync2_q  <= sync1_q;
            sync_d_q <= sync2_q;
            if (sync2_q != sync_d_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (settled) begin
                stable_q <= sync2_q;
            end
            rise_q <= settled && sync2_q && !stable_q;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/uart_sw_ctrl.sv
// Command sequencer: debounced button press either pushes a switch byte into the
// TX FIFO or schedules a frame-config update applied once the transmitter drains.
module uart_sw_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned      DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned      WR_TIMEOUT      = 1024,
    parameter logic [CFG_W-1:0] CFG_RESET       = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_switches,
    input  logic              i_sel,
    input  logic              i_btn,
    input  logic              i_fifo_full,
    input  logic              i_fifo_empty,
    input  logic              i_tx_busy,
    output logic              o_wr_en,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [CFG_W-1:0]  o_config,
    output logic              o_cfg_pending,
    output logic              o_cfg_update,
    output logic              o_drop
);

    localparam int unsigned      TO_W    = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(WR_TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] shadow_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CFG_W-1:0]  cfg_q;
    logic              cfg_upd_q;
    logic              cmd;
    logic              capture;
    logic              apply;
    logic              to_inc;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn),
        .o_rise  (cmd)
    );

    // Next-state and command-strobe decode; the command type is carried by the state entered
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        apply         = 1'b0;
        to_inc        = 1'b0;
        o_wr_en       = 1'b0;
        o_wr_data     = '0;
        o_drop        = 1'b0;
        o_cfg_pending = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    capture = 1'b1;
                    state_d = i_sel ? ST_WRITE : ST_CFG_WAIT;
                end
            end
            ST_WRITE: begin
                if (!i_fifo_full) begin
                    o_wr_en   = 1'b1;
                    o_wr_data = shadow_q;
                    state_d   = ST_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    o_drop  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_CFG_WAIT: begin
                o_cfg_pending = 1'b1;
                if (i_fifo_empty && !i_tx_busy) begin
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Presses while a command is outstanding are rejected
        if (cmd && (state_q != ST_IDLE)) begin
            o_drop = 1'b1;
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shadow capture, write timeout counter and active config register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q  <= '0;
            to_cnt_q  <= '0;
            cfg_q     <= CFG_RESET;
            cfg_upd_q <= 1'b0;
        end else begin
            if (capture) begin
                shadow_q <= i_switches;
            end
            if (to_inc) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (apply) begin
                cfg_q <= shadow_q[CFG_W-1:0];
            end
            cfg_upd_q <= apply;
        end
    end

    assign o_config     = cfg_q;
    assign o_cfg_update = cfg_upd_q;

endmodule

// File: tb/tb_uart_sw_ctrl.sv
// Scoreboard bench for uart_sw_ctrl: expected writes/configs queued at stimulus, checked at output.
module tb_uart_sw_ctrl;
    import uart_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned TO  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] switches = '0;
    logic              sel = 1'b0;
    logic              btn = 1'b0;
    logic              fifo_full = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              tx_busy = 1'b0;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [CFG_W-1:0]  config_out;
    logic              cfg_pending;
    logic              cfg_update;
    logic              drop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int drop_cnt = 0;
    int upd_cnt = 0;
    int last_wr_cyc = 0;
    int last_drop_cyc = 0;
    int t0 = 0;
    int lat = 0;
    int w0, d0, u0;

    logic [DATA_W-1:0] exp_wr[$];
    logic [CFG_W-1:0]  exp_cfg[$];

    uart_sw_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .WR_TIMEOUT      (TO),
        .CFG_RESET       (6'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_switches    (switches),
        .i_sel         (sel),
        .i_btn         (btn),
        .i_fifo_full   (fifo_full),
        .i_fifo_empty  (fifo_empty),
        .i_tx_busy     (tx_busy),
        .o_wr_en       (wr_en),
        .o_wr_data     (wr_data),
        .o_config      (config_out),
        .o_cfg_pending (cfg_pending),
        .o_cfg_update  (cfg_update),
        .o_drop        (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [DATA_W-1:0] sw, input logic s, input int hold);
        switches = sw;
        sel      = s;
        btn      = 1'b1;
        t0       = cyc;
        tick(hold);
        btn = 1'b0;
        tick(16);
    endtask

    task automatic bounce(input int toggles);
        for (int i = 0; i < toggles; i++) begin
            btn = ~btn;
            tick(2);
        end
    endtask

    // Output monitor: pops the scoreboard on every strobe, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(wr_data), 32'hFFFF_FFFF);
                else check("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
            end else if (wr_data != '0) begin
                check("wr_data_idle", 32'(wr_data), 32'h0);
            end
            if (drop) begin
                drop_cnt++;
                last_drop_cyc = cyc;
            end
            if (cfg_update) begin
                upd_cnt++;
                if (exp_cfg.size() == 0) check("cfg_unexpected", 32'(config_out), 32'hFFFF_FFFF);
                else check("cfg_value", 32'(config_out), 32'(exp_cfg.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_config", 32'(config_out), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_pending", 32'(cfg_pending), 32'h0);
        check("rst_update", 32'(cfg_update), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        rst_n = 1'b1;
        tick(8);

        // Clean write press
        w0 = wr_cnt; d0 = drop_cnt;
        exp_wr.push_back(8'hA5);
        press(8'hA5, 1'b1, 14);
        lat = last_wr_cyc - t0;
        check("t1_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("t1_latency_ok", 32'(lat >= int'(DEB + 2) && lat <= int'(DEB + 6)), 32'd1);
        check("t1_config", 32'(config_out), 32'h0);
        check("t1_drop", 32'(drop_cnt - d0), 32'd0);

        // Bouncing press then bouncing release
        w0 = wr_cnt; d0 = drop_cnt;
        exp_wr.push_back(8'h3C);
        switches = 8'h3C; sel = 1'b1;
        bounce(10);
        btn = 1'b1;
        tick(14);
        check("t2_wr_press", 32'(wr_cnt - w0), 32'd1);
        bounce(10);
        btn = 1'b0;
        tick(16);
        check("t2_wr_release", 32'(wr_cnt - w0), 32'd1);
        check("t2_drop", 32'(drop_cnt - d0), 32'd0);

        // FIFO full for the whole window: timeout drop, no write
        w0 = wr_cnt; d0 = drop_cnt;
        fifo_full = 1'b1;
        tick(2);
        press(8'h77, 1'b1, 14);
        tick(10);
        fifo_full = 1'b0;
        tick(10);
        check("t3_wr_none", 32'(wr_cnt - w0), 32'd0);
        check("t3_drop_count", 32'(drop_cnt - d0), 32'd1);
        check("t3_drop_cycle", 32'(last_drop_cyc - t0), 32'(lat + int'(TO) - 1));

        // FIFO full clears after 3 WRITE cycles: write in the 4th, no drop
        w0 = wr_cnt; d0 = drop_cnt;
        exp_wr.push_back(8'h81);
        fifo_full = 1'b1;
        switches = 8'h81; sel = 1'b1;
        btn = 1'b1;
        t0 = cyc;
        while (cyc < t0 + lat + 3) tick(1);
        fifo_full = 1'b0;
        tick(12);
        btn = 1'b0;
        tick(16);
        check("t3b_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("t3b_wr_cycle", 32'(last_wr_cyc - t0), 32'(lat + 3));
        check("t3b_drop", 32'(drop_cnt - d0), 32'd0);

        // Config deferred until FIFO empty and transmitter idle
        u0 = upd_cnt;
        tx_busy = 1'b1; fifo_empty = 1'b0;
        exp_cfg.push_back(6'h2D);
        press(8'h2D, 1'b0, 14);
        check("t4_pending", 32'(cfg_pending), 32'd1);
        check("t4_config_held", 32'(config_out), 32'h0);
        tx_busy = 1'b0;
        tick(5);
        check("t4_pending_not_empty", 32'(cfg_pending), 32'd1);
        check("t4_update_none", 32'(upd_cnt - u0), 32'd0);
        fifo_empty = 1'b1;
        tick(3);
        check("t4_pending_clear", 32'(cfg_pending), 32'd0);
        check("t4_config", 32'(config_out), 32'h2D);
        check("t4_parity_en", 32'(config_out[CFG_PARITY_EN]), 32'd1);
        check("t4_update_count", 32'(upd_cnt - u0), 32'd1);

        // Second press while config pending is dropped; first capture wins
        u0 = upd_cnt; w0 = wr_cnt;
        tx_busy = 1'b1; fifo_empty = 1'b0;
        exp_cfg.push_back(6'h1A);
        press(8'h1A, 1'b0, 14);
        d0 = drop_cnt;
        press(8'h3F, 1'b1, 14);
        check("t5_drop", 32'(drop_cnt - d0), 32'd1);
        check("t5_pending", 32'(cfg_pending), 32'd1);
        tx_busy = 1'b0; fifo_empty = 1'b1;
        tick(3);
        check("t5_config", 32'(config_out), 32'h1A);
        check("t5_update_count", 32'(upd_cnt - u0), 32'd1);
        check("t5_wr_none", 32'(wr_cnt - w0), 32'd0);

        // Asynchronous reset while config pending
        u0 = upd_cnt;
        tx_busy = 1'b1; fifo_empty = 1'b0;
        press(8'h35, 1'b0, 14);
        check("t6_pending", 32'(cfg_pending), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_config", 32'(config_out), 32'h0);
        check("t6_rst_pending", 32'(cfg_pending), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tx_busy = 1'b0; fifo_empty = 1'b1;
        tick(20);
        check("t6_update_none", 32'(upd_cnt - u0), 32'd0);
        check("t6_config_after", 32'(config_out), 32'h0);

        check("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
        check("sb_cfg_empty", 32'(exp_cfg.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
